// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks (subtractor and the
// sequential adders): the load/compute/result state encoding, the default
// operand width, and the single-bit sum/difference and carry/borrow helpers.
package serial_arith_pkg;

    // Default operand width for the serial arithmetic blocks
    localparam int SER_WIDTH = 8;

    // Load / compute / result sequencing shared by the serial blocks
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Full-subtractor difference bit: x - y - bin
    function automatic logic sub_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Full-subtractor borrow out: borrow when y exceeds x, or when x equals y
    // and a borrow is already pending
    function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    // Full-adder sum bit: x + y + cin
    function automatic logic add_sum(input logic x, input logic y, input logic cin);
        return x ^ y ^ cin;
    endfunction

    // Full-adder carry out
    function automatic logic add_carry(input logic x, input logic y, input logic cin);
        return (x & y) | ((x ^ y) & cin);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell
// Combinational 1-bit full subtractor computing x - y - bin.
// Ports:
//   x   : minuend bit
//   y   : subtrahend bit
//   bin : borrow in
//   d   : difference bit
//   bo  : borrow out
module full_sub_cell
    import serial_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = sub_diff(x, y, bin);
    assign bo = sub_borrow(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor, LSB first. Computes a - b (mod 2^WIDTH) over
// WIDTH SHIFT cycles using a single full_sub_cell and a borrow flip-flop, then
// publishes the result in the DONE state.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   start : request an operation (only honoured in IDLE)
//   a, b  : minuend / subtrahend, captured on the start cycle
//   diff  : registered result, held until the next completion
//   bout  : final borrow, 1 when a < b
//   busy  : high in SHIFT and DONE
//   done  : one-cycle pulse coinciding with diff/bout being updated
//   ovf   : two's-complement overflow (only with SERIAL_SUB_SIGNED_EN defined)
// Optional feature macro: SERIAL_SUB_SIGNED_EN adds the ovf output.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
`ifdef SERIAL_SUB_SIGNED_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] rr;
    logic             borrow;
    logic             d_bit;
    logic             bo_bit;

`ifdef SERIAL_SUB_SIGNED_EN
    // Operand sign bits survive the shifting, so they are kept separately
    logic             a_msb;
    logic             b_msb;
`endif

    // One full-subtractor cell works on the current LSBs of the shifters
    full_sub_cell u_cell (
        .x   (sa[0]),
        .y   (sb[0]),
        .bin (borrow),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; SHIFT ends on the cycle that processes the last bit
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (count == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand load, serial shift, and result publication. Outputs
    // only change in DONE, so partial results never reach the ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            sa     <= '0;
            sb     <= '0;
            rr     <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        count  <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    rr     <= {d_bit, rr[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= bo_bit;
                    count  <= count + CW'(1);
                end
                DONE: begin
                    diff <= rr;
                    bout <= borrow;
                    done <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_EN
                    ovf  <= (a_msb != b_msb) && (rr[WIDTH-1] != a_msb);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed testbench for serial_subtractor (WIDTH=8). Expected results are
// computed from the operands with ordinary arithmetic, queued when an
// operation is started, and compared when done pulses.
// Optional feature macro: SERIAL_SUB_SIGNED_EN (adds the ovf checks).
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_SIGNED_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   testCount;
    int   failCount;
    int   cycles;
    int   busyCnt;
    int   doneSeen;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef SERIAL_SUB_SIGNED_EN
        .ovf   (ovf),
`endif
        .done  (done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when it does not hold
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start, queue the expected result, then scramble the
    // operand inputs so later changes are shown not to matter
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        e;
        logic [W-1:0] d;
        d      = av - bv;
        e.diff = d;
        e.bout = (av < bv);
        e.ovf  = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
        sb.push_back(e);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Wait (bounded) for done, measuring latency and busy length, then pop the
    // scoreboard and compare the published result
    task automatic checkOutput(output int nCycles, output int nBusy);
        exp_t e;
        nCycles = 0;
        nBusy   = 0;
        while (done !== 1'b1 && nCycles < 40) begin
            if (busy === 1'b1) nBusy++;
            @(posedge clk);
            #1;
            nCycles++;
        end
        checkVal("done_timeout", done, 1);
        checkVal("busy_at_done", busy, 0);
        checkVal("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkVal("diff", diff, e.diff);
            checkVal("bout", bout, e.bout);
`ifdef SERIAL_SUB_SIGNED_EN
            checkVal("ovf", ovf, e.ovf);
`endif
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        #3;
        checkVal("rst_diff", diff, 0);
        checkVal("rst_bout", bout, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
`ifdef SERIAL_SUB_SIGNED_EN
        checkVal("rst_ovf", ovf, 0);
`endif
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic subtraction with latency and busy-length checks
        applyStimulus(8'h65, 8'h23);
        checkOutput(cycles, busyCnt);
        checkVal("latency_65_23", cycles, W + 1);
        checkVal("busy_len_65_23", busyCnt, W + 1);

        // done is a single-cycle pulse
        @(posedge clk);
        #1;
        checkVal("done_pulse_width", done, 0);

        applyStimulus(8'h23, 8'h65);
        checkOutput(cycles, busyCnt);
        applyStimulus(8'hE5, 8'hE5);
        checkOutput(cycles, busyCnt);

        // Full borrow ripple, then back-to-back start on the done cycle
        applyStimulus(8'h00, 8'h01);
        checkOutput(cycles, busyCnt);
        applyStimulus(8'h10, 8'h01);
        checkOutput(cycles, busyCnt);
        checkVal("latency_b2b", cycles, W + 1);

        // Asynchronous reset in the middle of SHIFT
        applyStimulus(8'h65, 8'h23);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b0;
        #1;
        checkVal("async_rst_diff", diff, 0);
        checkVal("async_rst_bout", bout, 0);
        checkVal("async_rst_busy", busy, 0);
        checkVal("async_rst_done", done, 0);
`ifdef SERIAL_SUB_SIGNED_EN
        checkVal("async_rst_ovf", ovf, 0);
`endif
        sb.delete();
        #2;
        rst = 1'b1;
        doneSeen = 0;
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkVal("no_activity_after_abort", doneSeen, 0);
        applyStimulus(8'h65, 8'h23);
        checkOutput(cycles, busyCnt);

        // start during SHIFT is ignored
        applyStimulus(8'h65, 8'h23);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput(cycles, busyCnt);
        repeat (2 * W) begin
            @(posedge clk);
            #1;
        end
        checkVal("ignored_start_idle", busy, 0);

        // Signed-overflow vectors (diff/bout checked in every build)
        applyStimulus(8'h7F, 8'hFF);
        checkOutput(cycles, busyCnt);
        applyStimulus(8'h05, 8'h03);
        checkOutput(cycles, busyCnt);
        applyStimulus(8'h80, 8'h01);
        checkOutput(cycles, busyCnt);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor, LSB first. It computes a − b for two WIDTH-bit operands over WIDTH clock cycles, using one full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's sequential adders and uses the same load/compute/result style. It sits beside them in the memory-elements/arithmetic set, and the existing adder benches can drive it.

Parameters:
WIDTH, 8, operand and result width in bits (must be ≥ 2)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; sampled on the start cycle
b  input  WIDTH  subtrahend; sampled on the start cycle
diff  output  WIDTH  registered result a − b (mod 2^WIDTH)
bout  output  1  final borrow out; 1 when a < b (unsigned)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when diff/bout are updated

Behaviour:
- Reset: rst=0 forces the following immediately, regardless of clk:
  - state=IDLE, counter=0, borrow=0, shift registers=0
  - diff=0, bout=0, busy=0, done=0
- Reset mid-operation aborts the operation with no partial result. After rst returns to 1, the block waits in IDLE for a new start.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads a→sa, b→sb, borrow←0, count←0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each cycle:
  - d = sa[0]^sb[0]^borrow
  - borrow ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow)
  - d is shifted into the MSB of the internal result register rr; sa and sb shift right by one.
  - count increments. When count reaches WIDTH−1 in this cycle, the next state is DONE.
- SHIFT therefore lasts exactly WIDTH cycles.
- DONE, one cycle:
  - diff ← rr, bout ← borrow, done=1
  - next state is IDLE
- Latency: with start sampled at rising edge k, done=1 during the cycle after edge k+WIDTH+1. A new start is accepted on the edge that ends the DONE cycle (back-to-back operation is allowed).
- busy=1 in SHIFT and DONE, 0 in IDLE.
- diff and bout hold their previous values until the next DONE. Partial results never appear on the ports.
- start while busy is ignored. No queueing, no error.
- a and b may change freely after the start cycle without affecting the result.
- Arithmetic: pure unsigned modulo-2^WIDTH. diff = (a − b) mod 2^WIDTH, bout = (a < b).

Optional Feature:
SERIAL_SUB_SIGNED_EN
- Defined:
  - An extra output port ovf (1 bit) is added.
  - ovf is registered at DONE together with diff: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), i.e. two's-complement overflow.
  - ovf resets to 0 and holds until the next DONE.
  - The MSBs of a and b are captured at start.
- Undefined: the ovf port and its logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - default width constant SER_WIDTH=8
  - borrow/carry function helpers, reusable by the sequential adders
- One sub-module: full_sub_cell. It is a combinational 1-bit full subtractor with inputs x, y, bin and outputs d, bo, instantiated once inside serial_subtractor.

Test Plan:
- a=0x65, b=0x23, start pulse → done after WIDTH+1 edges; diff=0x42, bout=0; busy high for exactly 9 cycles.
- a=0x23, b=0x65 → diff=0xBE, bout=1; a=0xE5, b=0xE5 → diff=0x00, bout=0.
- a=0x00, b=0x01 → diff=0xFF, bout=1 (borrow ripples through all bits). Then back-to-back start at the DONE edge with a=0x10, b=0x01 → diff=0x0F.
- Start an operation (a=0x65, b=0x23), then pulse rst=0 asynchronously in the middle of SHIFT (between edges) → all outputs 0 immediately; no done pulse follows; a fresh start then yields correct 0x42.
- start re-asserted with a=0xFF, b=0x00 during SHIFT → ignored; result is still that of the first operation.
- SERIAL_SUB_SIGNED_EN defined: a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1; a=0x05, b=0x03 → diff=0x02, ovf=0.
